// File: rtl/hex8_sched_pkg.sv
// Shared types and constants for the hex8 display scheduler.
// Frame width, source count and the FSM state encoding live here.
package hex8_sched_pkg;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int FRAME_W = 32;

    localparam logic [FRAME_W-1:0] RST_FRAME = 32'h0000_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One-hot Ack vector for a given source index.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] src);
        return {{(NUM_SRC-1){1'b0}}, 1'b1} << src;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Searches last+1, last+2, ... modulo 4, so a lone last requester wins again.
module rr_pick4
    import hex8_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   last_i,
    output logic               any_o,
    output logic [SRC_W-1:0]   winner_o
);

    logic             found_s;
    logic [SRC_W-1:0] cand_s;

    // First set request bit in rotated order starting after last_i.
    always_comb begin
        any_o    = |req_i;
        winner_o = last_i;
        found_s  = 1'b0;
        cand_s   = last_i;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_s = last_i + SRC_W'(k);
            if (!found_s && req_i[cand_s]) begin
                winner_o = cand_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

endmodule

// File: rtl/hex8_disp_sched.sv
// Round-robin scheduler sharing one 8-digit hex display between four frame sources.
// A granted frame dwells DWELL_CYC cycles; expiry with pending requests reloads directly.
module hex8_disp_sched
    import hex8_sched_pkg::*;
#(
    parameter int DWELL_CYC = 50_000_000
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [NUM_SRC-1:0]           Req,
    input  logic [NUM_SRC*FRAME_W-1:0]   Req_data,
    output logic [NUM_SRC-1:0]           Ack,
    output logic [FRAME_W-1:0]           Disp_data,
    output logic [SRC_W-1:0]             Cur_src,
    output logic                         Frame_stb,
    output logic                         Busy
);

    localparam int               CNT_W   = $clog2(DWELL_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYC - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic [FRAME_W-1:0]   disp_q, disp_d;
    logic [SRC_W-1:0]     cur_q, cur_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic                 stb_q, stb_d;
    logic                 busy_q, busy_d;

    logic                 any_s;
    logic [SRC_W-1:0]     win_s;
    logic                 load_s;

    rr_pick4 u_pick (
        .req_i    (Req),
        .last_i   (last_q),
        .any_o    (any_s),
        .winner_o (win_s)
    );

    // Next-state: grant from IDLE or at dwell expiry, otherwise count the dwell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        disp_d  = disp_q;
        cur_d   = cur_q;
        ack_d   = {NUM_SRC{1'b0}};
        load_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_MAX) begin
                    if (any_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        if (load_s) begin
            state_d = HOLD;
            cnt_d   = {CNT_W{1'b0}};
            last_d  = win_s;
            cur_d   = win_s;
            disp_d  = Req_data[FRAME_W*win_s +: FRAME_W];
            ack_d   = src_onehot(win_s);
        end else begin
            ack_d   = {NUM_SRC{1'b0}};
        end

        stb_d  = |ack_d;
        busy_d = (state_d == HOLD);
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            last_q  <= SRC_W'(NUM_SRC - 1);
            disp_q  <= RST_FRAME;
            cur_q   <= {SRC_W{1'b0}};
            ack_q   <= {NUM_SRC{1'b0}};
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
        end
    end

    assign Ack       = ack_q;
    assign Disp_data = disp_q;
    assign Cur_src   = cur_q;
    assign Frame_stb = stb_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_hex8_disp_sched.sv
// Directed bench for hex8_disp_sched with DWELL_CYC = 8: vector table for
// single-source, round-robin and skip fairness, hand sequences for the rest.
module tb_hex8_disp_sched;

    logic         Clk;
    logic         Reset_n;
    logic [3:0]   Req;
    logic [127:0] Req_data;
    logic [3:0]   Ack;
    logic [31:0]  Disp_data;
    logic [1:0]   Cur_src;
    logic         Frame_stb;
    logic         Busy;

    int n_cmp;
    int n_err;

    hex8_disp_sched #(.DWELL_CYC(8)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .Req_data  (Req_data),
        .Ack       (Ack),
        .Disp_data (Disp_data),
        .Cur_src   (Cur_src),
        .Frame_stb (Frame_stb),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string        name;
        logic         do_rst;
        logic [3:0]   req;
        logic [127:0] data;
        int           ncyc;
        logic [3:0]   ack;
        logic [31:0]  disp;
        logic [1:0]   cur;
        logic         stb;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_ack, input logic [31:0] e_disp,
                         input logic [1:0] e_cur, input logic e_stb, input logic e_busy);
        n_cmp++;
        if (Ack !== e_ack) begin
            n_err++;
            $display("FAIL %s Ack got %b want %b", name, Ack, e_ack);
        end
        n_cmp++;
        if (Disp_data !== e_disp) begin
            n_err++;
            $display("FAIL %s Disp_data got %h want %h", name, Disp_data, e_disp);
        end
        n_cmp++;
        if (Cur_src !== e_cur) begin
            n_err++;
            $display("FAIL %s Cur_src got %0d want %0d", name, Cur_src, e_cur);
        end
        n_cmp++;
        if (Frame_stb !== e_stb) begin
            n_err++;
            $display("FAIL %s Frame_stb got %b want %b", name, Frame_stb, e_stb);
        end
        n_cmp++;
        if (Busy !== e_busy) begin
            n_err++;
            $display("FAIL %s Busy got %b want %b", name, Busy, e_busy);
        end
    endtask

    task automatic pulse_reset();
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] da;
        logic [31:0]  f1;
        logic [31:0]  fa [4];

        n_cmp = 0;
        n_err = 0;
        f1    = 32'h1234_5678;
        d1    = {32'h0000_0000, f1, 64'h0};
        fa[0] = 32'h1111_1111;
        fa[1] = 32'h2222_2222;
        fa[2] = 32'h3333_3333;
        fa[3] = 32'h4444_4444;
        da    = {fa[3], fa[2], fa[1], fa[0]};

        // name, rst, req, data, ncyc, ack, disp, cur, stb, busy
        vecs.push_back('{"t1_load",   1'b0, 4'b0100, d1, 1, 4'b0100, f1,    2'd2, 1'b1, 1'b1});
        vecs.push_back('{"t1_ackcyc", 1'b0, 4'b0000, d1, 1, 4'b0000, f1,    2'd2, 1'b0, 1'b1});
        vecs.push_back('{"t1_hold",   1'b0, 4'b0000, d1, 6, 4'b0000, f1,    2'd2, 1'b0, 1'b1});
        vecs.push_back('{"t1_idle",   1'b0, 4'b0000, d1, 1, 4'b0000, f1,    2'd2, 1'b0, 1'b0});
        vecs.push_back('{"t1_stay",   1'b0, 4'b0000, d1, 3, 4'b0000, f1,    2'd2, 1'b0, 1'b0});
        vecs.push_back('{"t2_g0",     1'b1, 4'b1111, da, 1, 4'b0001, fa[0], 2'd0, 1'b1, 1'b1});
        vecs.push_back('{"t2_h0",     1'b0, 4'b1111, da, 7, 4'b0000, fa[0], 2'd0, 1'b0, 1'b1});
        vecs.push_back('{"t2_g1",     1'b0, 4'b1111, da, 1, 4'b0010, fa[1], 2'd1, 1'b1, 1'b1});
        vecs.push_back('{"t2_h1",     1'b0, 4'b1111, da, 7, 4'b0000, fa[1], 2'd1, 1'b0, 1'b1});
        vecs.push_back('{"t2_g2",     1'b0, 4'b1111, da, 1, 4'b0100, fa[2], 2'd2, 1'b1, 1'b1});
        vecs.push_back('{"t2_h2",     1'b0, 4'b1111, da, 7, 4'b0000, fa[2], 2'd2, 1'b0, 1'b1});
        vecs.push_back('{"t2_g3",     1'b0, 4'b1111, da, 1, 4'b1000, fa[3], 2'd3, 1'b1, 1'b1});
        vecs.push_back('{"t2_h3",     1'b0, 4'b1111, da, 7, 4'b0000, fa[3], 2'd3, 1'b0, 1'b1});
        vecs.push_back('{"t2_g0b",    1'b0, 4'b1111, da, 1, 4'b0001, fa[0], 2'd0, 1'b1, 1'b1});
        vecs.push_back('{"t3_h0",     1'b0, 4'b1001, da, 7, 4'b0000, fa[0], 2'd0, 1'b0, 1'b1});
        vecs.push_back('{"t3_g3",     1'b0, 4'b1001, da, 1, 4'b1000, fa[3], 2'd3, 1'b1, 1'b1});
        vecs.push_back('{"t3_h3",     1'b0, 4'b1001, da, 7, 4'b0000, fa[3], 2'd3, 1'b0, 1'b1});
        vecs.push_back('{"t3_g0",     1'b0, 4'b1001, da, 1, 4'b0001, fa[0], 2'd0, 1'b1, 1'b1});
        vecs.push_back('{"t3_h0b",    1'b0, 4'b1001, da, 7, 4'b0000, fa[0], 2'd0, 1'b0, 1'b1});
        vecs.push_back('{"t3_g3b",    1'b0, 4'b1001, da, 1, 4'b1000, fa[3], 2'd3, 1'b1, 1'b1});
        vecs.push_back('{"t3_drop",   1'b0, 4'b0000, da, 7, 4'b0000, fa[3], 2'd3, 1'b0, 1'b1});
        vecs.push_back('{"t3_idle",   1'b0, 4'b0000, da, 1, 4'b0000, fa[3], 2'd3, 1'b0, 1'b0});

        Req      = 4'b0000;
        Req_data = 128'h0;
        Reset_n  = 1'b0;
        tick(2);
        check("reset", 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        tick(2);
        check("idle_no_req", 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) pulse_reset();
            Req      = vecs[i].req;
            Req_data = vecs[i].data;
            tick(vecs[i].ncyc);
            check(vecs[i].name, vecs[i].ack, vecs[i].disp, vecs[i].cur, vecs[i].stb, vecs[i].busy);
        end

        // Withdrawn request on source 1 while source 0 holds (last = 3, IDLE).
        Req      = 4'b0001;
        Req_data = {32'h0, 32'hDEAD_0002, 32'h0, 32'hA5A5_0001};
        tick(1);
        check("t4_load0", 4'b0001, 32'hA5A5_0001, 2'd0, 1'b1, 1'b1);
        Req = 4'b0000;
        tick(2);
        Req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check("t4_pulse", 4'b0000, 32'hA5A5_0001, 2'd0, 1'b0, 1'b1);
        end
        Req = 4'b0000;
        tick(2);
        check("t4_last", 4'b0000, 32'hA5A5_0001, 2'd0, 1'b0, 1'b1);
        tick(1);
        check("t4_idle", 4'b0000, 32'hA5A5_0001, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of HOLD with source 1 still requesting (last = 0).
        Req      = 4'b0010;
        Req_data = {32'h0, 32'h0, 32'hCAFE_0002, 32'h0};
        tick(1);
        check("t5_load1", 4'b0010, 32'hCAFE_0002, 2'd1, 1'b1, 1'b1);
        tick(4);
        check("t5_cnt4", 4'b0000, 32'hCAFE_0002, 2'd1, 1'b0, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("t5_async", 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
        tick(2);
        check("t5_held", 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        tick(1);
        check("t5_regrant", 4'b0010, 32'hCAFE_0002, 2'd1, 1'b1, 1'b1);

        // Lone source 2 re-granted every 8 cycles; data only sampled at grants.
        pulse_reset();
        Req      = 4'b0100;
        Req_data = {32'h0, 32'h0000_0001, 64'h0};
        tick(1);
        check("t6_g1", 4'b0100, 32'h0000_0001, 2'd2, 1'b1, 1'b1);
        Req_data = {32'h0, 32'h0000_0002, 64'h0};
        tick(3);
        check("t6_mid", 4'b0000, 32'h0000_0001, 2'd2, 1'b0, 1'b1);
        tick(4);
        check("t6_end", 4'b0000, 32'h0000_0001, 2'd2, 1'b0, 1'b1);
        tick(1);
        check("t6_g2", 4'b0100, 32'h0000_0002, 2'd2, 1'b1, 1'b1);
        Req_data = {32'h0, 32'h0000_0003, 64'h0};
        tick(7);
        check("t6_end2", 4'b0000, 32'h0000_0002, 2'd2, 1'b0, 1'b1);
        tick(1);
        check("t6_g3", 4'b0100, 32'h0000_0003, 2'd2, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
